prim_wr_buffer: RTL and testbench

- Sits directly downstream of the primitive renderer. It accepts the renderer's VRAM pixel-write requests (address, nibble mask, data) and buffers them in a small FIFO.
- It coalesces writes to the same VRAM word and drains them to the VRAM arbiter using a request/ack handshake.
- It generates the renderer's output-enable (throttle), so no write is lost while the arbiter is servicing other masters.

---
 rtl/prim_wr_buffer_pkg.sv | 13 +
 rtl/prim_wr_buffer.sv | 125 ++++++++++++
 tb/tb_prim_wr_buffer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/prim_wr_buffer_pkg.sv
// Shared types and sizing for the primitive-renderer VRAM write buffer.
package prim_wr_buffer_pkg;

  localparam int PRWB_DEPTH = 8;
  localparam int PRWB_SLACK = 2;

  typedef struct packed {
    logic [3:0]  mask;
    logic [15:0] addr;
    logic [15:0] data;
  } prwb_entry_t;

endpackage

// File: rtl/prim_wr_buffer.sv
// Write-coalescing FIFO between the primitive renderer and the VRAM arbiter.
// The head entry is held stable until acked; newer writes to the tail address merge in place.
module prim_wr_buffer
  import prim_wr_buffer_pkg::*;
#(
  parameter int DEPTH = PRWB_DEPTH,
  parameter int SLACK = PRWB_SLACK
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        in_valid_i,
  input  logic [3:0]  in_mask_i,
  input  logic [15:0] in_addr_i,
  input  logic [15:0] in_data_i,
  output logic        oe_o,
  output logic        vram_sel_o,
  output logic        vram_wr_o,
  output logic [3:0]  vram_mask_o,
  output logic [15:0] vram_addr_o,
  output logic [15:0] vram_data_o,
  input  logic        vram_ack_i,
  output logic        busy_o,
  output logic        overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  prwb_entry_t      mem_q [DEPTH];
  prwb_entry_t      mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [AW-1:0]    tail_ptr_s;
  logic             not_empty_s;
  logic             pop_s;
  logic             merge_s;
  logic             push_s;
  logic             drop_s;
  prwb_entry_t      head_s;

  function automatic logic addr_hit(input prwb_entry_t e, input logic [15:0] a);
    return (e.addr == a);
  endfunction

  function automatic prwb_entry_t merge_entry(input prwb_entry_t e, input logic [3:0] m,
                                              input logic [15:0] d);
    prwb_entry_t r;
    r = e;
    r.mask = e.mask | m;
    for (int n = 0; n < 4; n++) begin
      if (m[n]) begin
        r.data[4*n +: 4] = d[4*n +: 4];
      end else begin
        r.data[4*n +: 4] = e.data[4*n +: 4];
      end
    end
    return r;
  endfunction

  // Input classification and next-state for storage, pointers and count.
  always_comb begin
    tail_ptr_s  = wr_ptr_q - AW'(1);
    not_empty_s = (cnt_q != '0);
    pop_s       = vram_ack_i & not_empty_s;
    // Merging needs count>=2 so the locked head is never the tail.
    merge_s     = in_valid_i && (cnt_q >= CW'(2)) && addr_hit(mem_q[tail_ptr_s], in_addr_i);
    push_s      = in_valid_i && !merge_s && ((cnt_q < CW'(DEPTH)) || pop_s);
    drop_s      = in_valid_i && !merge_s && !push_s;

    mem_d = mem_q;
    if (merge_s) begin
      mem_d[tail_ptr_s] = merge_entry(mem_q[tail_ptr_s], in_mask_i, in_data_i);
    end else if (push_s) begin
      mem_d[wr_ptr_q] = '{mask: in_mask_i, addr: in_addr_i, data: in_data_i};
    end else begin
      mem_d = mem_q;
    end

    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

    if (push_s && !pop_s) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop_s && !push_s) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    ovf_d = ovf_q | drop_s;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign head_s      = not_empty_s ? mem_q[rd_ptr_q] : '0;
  assign vram_sel_o  = not_empty_s;
  assign vram_wr_o   = not_empty_s;
  assign vram_mask_o = head_s.mask;
  assign vram_addr_o = head_s.addr;
  assign vram_data_o = head_s.data;
  assign busy_o      = not_empty_s;
  assign overflow_o  = ovf_q;
  assign oe_o        = ((CW'(DEPTH) - cnt_q) > CW'(SLACK));

endmodule

// File: tb/tb_prim_wr_buffer.sv
// Self-checking bench: queue-based model of the write buffer plus directed literal checks.
module tb_prim_wr_buffer;
  import prim_wr_buffer_pkg::*;

  logic        clk;
  logic        reset_n_i;
  logic        in_valid_i;
  logic [3:0]  in_mask_i;
  logic [15:0] in_addr_i;
  logic [15:0] in_data_i;
  logic        oe_o;
  logic        vram_sel_o;
  logic        vram_wr_o;
  logic [3:0]  vram_mask_o;
  logic [15:0] vram_addr_o;
  logic [15:0] vram_data_o;
  logic        vram_ack_i;
  logic        busy_o;
  logic        overflow_o;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  prwb_entry_t mq[$];
  bit          movf;
  int          m_sz;
  bit          m_pop;
  prwb_entry_t m_e;
  prwb_entry_t c_h;

  prim_wr_buffer dut (
    .clk        (clk),
    .reset_n_i  (reset_n_i),
    .in_valid_i (in_valid_i),
    .in_mask_i  (in_mask_i),
    .in_addr_i  (in_addr_i),
    .in_data_i  (in_data_i),
    .oe_o       (oe_o),
    .vram_sel_o (vram_sel_o),
    .vram_wr_o  (vram_wr_o),
    .vram_mask_o(vram_mask_o),
    .vram_addr_o(vram_addr_o),
    .vram_data_o(vram_data_o),
    .vram_ack_i (vram_ack_i),
    .busy_o     (busy_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a queue of pending writes; merge into the newest, push, or drop.
  always @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      m_sz  = mq.size();
      m_pop = vram_ack_i && (m_sz > 0);
      if (in_valid_i) begin
        if (m_sz >= 2 && mq[m_sz-1].addr == in_addr_i) begin
          m_e = mq[m_sz-1];
          m_e.mask = m_e.mask | in_mask_i;
          for (int n = 0; n < 4; n++)
            if (in_mask_i[n]) m_e.data[4*n +: 4] = in_data_i[4*n +: 4];
          mq[m_sz-1] = m_e;
        end else if (m_sz < 8 || m_pop) begin
          m_e.mask = in_mask_i;
          m_e.addr = in_addr_i;
          m_e.data = in_data_i;
          mq.push_back(m_e);
        end else begin
          movf = 1'b1;
        end
      end
      if (m_pop) void'(mq.pop_front());
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset_n_i && chk_en) begin
      c_h = (mq.size() != 0) ? mq[0] : '0;
      chk("sel",  {31'd0, vram_sel_o},  {31'd0, mq.size() != 0});
      chk("wr",   {31'd0, vram_wr_o},   {31'd0, mq.size() != 0});
      chk("mask", {28'd0, vram_mask_o}, {28'd0, c_h.mask});
      chk("addr", {16'd0, vram_addr_o}, {16'd0, c_h.addr});
      chk("data", {16'd0, vram_data_o}, {16'd0, c_h.data});
      chk("busy", {31'd0, busy_o},      {31'd0, mq.size() != 0});
      chk("oe",   {31'd0, oe_o},        {31'd0, (8 - mq.size()) > 2});
      chk("ovf",  {31'd0, overflow_o},  {31'd0, movf});
    end
  end

  task automatic step(input logic v, input logic [3:0] m, input logic [15:0] a,
                      input logic [15:0] d, input logic ack);
    in_valid_i = v;
    in_mask_i  = m;
    in_addr_i  = a;
    in_data_i  = d;
    vram_ack_i = ack;
    @(negedge clk);
  endtask

  task automatic idle(input logic ack);
    step(1'b0, 4'h0, 16'h0000, 16'h0000, ack);
  endtask

  logic [15:0] exp_addr [8];

  initial begin
    reset_n_i  = 1'b0;
    in_valid_i = 1'b0;
    in_mask_i  = 4'h0;
    in_addr_i  = 16'h0000;
    in_data_i  = 16'h0000;
    vram_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sel",  {31'd0, vram_sel_o}, 32'd0);
    chk("rst_oe",   {31'd0, oe_o},       32'd1);
    chk("rst_busy", {31'd0, busy_o},     32'd0);
    chk("rst_ovf",  {31'd0, overflow_o}, 32'd0);
    chk("rst_addr", {16'd0, vram_addr_o}, 32'd0);
    reset_n_i = 1'b1;
    chk_en    = 1'b1;
    @(negedge clk);

    // Single write with ack held high.
    step(1'b1, 4'hC, 16'h1234, 16'h5A5A, 1'b1);
    chk("single_sel",  {31'd0, vram_sel_o},  32'd1);
    chk("single_addr", {16'd0, vram_addr_o}, 32'h1234);
    chk("single_mask", {28'd0, vram_mask_o}, 32'hC);
    chk("single_data", {16'd0, vram_data_o}, 32'h5A5A);
    idle(1'b1);
    chk("single_busy", {31'd0, busy_o}, 32'd0);

    // Merge into the tail.
    step(1'b1, 4'hC, 16'h0010, 16'hAA00, 1'b0);
    step(1'b1, 4'hC, 16'h0020, 16'hBB00, 1'b0);
    step(1'b1, 4'h3, 16'h0020, 16'h00CC, 1'b0);
    chk("merge_head", {16'd0, vram_addr_o}, 32'h0010);
    idle(1'b1);
    chk("merge_addr", {16'd0, vram_addr_o}, 32'h0020);
    chk("merge_mask", {28'd0, vram_mask_o}, 32'hF);
    chk("merge_data", {16'd0, vram_data_o}, 32'hBBCC);
    idle(1'b1);
    chk("merge_drained", {31'd0, busy_o}, 32'd0);

    // Head lock: same address at count==1 pushes instead of merging.
    step(1'b1, 4'hC, 16'h0040, 16'h1100, 1'b0);
    step(1'b1, 4'h3, 16'h0040, 16'h0022, 1'b0);
    chk("lock_mask", {28'd0, vram_mask_o}, 32'hC);
    chk("lock_data", {16'd0, vram_data_o}, 32'h1100);
    idle(1'b1);
    chk("lock_2nd_mask", {28'd0, vram_mask_o}, 32'h3);
    chk("lock_2nd_data", {16'd0, vram_data_o}, 32'h0022);
    idle(1'b1);
    chk("lock_drained", {31'd0, busy_o}, 32'd0);

    // Full buffer with a simultaneous ack accepts the write.
    for (int i = 0; i < 8; i++) step(1'b1, 4'hF, 16'h0300 + 16'(i), 16'(i), 1'b0);
    chk("full_oe", {31'd0, oe_o}, 32'd0);
    step(1'b1, 4'hF, 16'h0200, 16'hCAFE, 1'b1);
    chk("full_ack_ovf",  {31'd0, overflow_o},  32'd0);
    chk("full_ack_head", {16'd0, vram_addr_o}, 32'h0301);
    for (int i = 0; i < 7; i++) exp_addr[i] = 16'h0301 + 16'(i);
    exp_addr[7] = 16'h0200;
    for (int i = 0; i < 8; i++) begin
      chk("full_drain", {16'd0, vram_addr_o}, {16'd0, exp_addr[i]});
      idle(1'b1);
    end
    chk("full_drained", {31'd0, busy_o}, 32'd0);

    // Throttle and overflow.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 4'hF, 16'h0100 + 16'(i), 16'h1000 + 16'(i), 1'b0);
      if (i == 4) chk("thr_oe5", {31'd0, oe_o}, 32'd1);
      if (i == 5) chk("thr_oe6", {31'd0, oe_o}, 32'd0);
      if (i == 7) chk("thr_ovf8", {31'd0, overflow_o}, 32'd0);
      if (i == 8) chk("thr_ovf9", {31'd0, overflow_o}, 32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      chk("thr_drain", {16'd0, vram_addr_o}, {16'd0, 16'h0100 + 16'(i)});
      idle(1'b1);
    end
    chk("thr_drained", {31'd0, busy_o}, 32'd0);
    chk("thr_sticky",  {31'd0, overflow_o}, 32'd1);

    // Async reset in the middle of a drain.
    for (int i = 0; i < 5; i++) step(1'b1, 4'hF, 16'h0400 + 16'(i), 16'(i), 1'b0);
    in_valid_i = 1'b0;
    @(posedge clk);
    #2 reset_n_i = 1'b0;
    #1;
    chk("arst_sel",  {31'd0, vram_sel_o}, 32'd0);
    chk("arst_busy", {31'd0, busy_o},     32'd0);
    chk("arst_oe",   {31'd0, oe_o},       32'd1);
    chk("arst_ovf",  {31'd0, overflow_o}, 32'd0);
    #1 reset_n_i = 1'b1;
    @(negedge clk);
    step(1'b1, 4'hC, 16'h0500, 16'h1357, 1'b0);
    chk("post_rst_addr", {16'd0, vram_addr_o}, 32'h0500);
    chk("post_rst_data", {16'd0, vram_data_o}, 32'h1357);
    idle(1'b1);
    chk("post_rst_busy", {31'd0, busy_o}, 32'd0);

    idle(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
